floor_request_sorter: RTL and testbench



---
 rtl/floor_request_sorter_if.sv | 31 +++
 rtl/floor_request_sorter.sv | 158 +++++++++++++++
 tb/tb_floor_request_sorter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/floor_request_sorter_if.sv
// Request/result bundle between request capture, the sorter and the motion controller.
interface floor_request_sorter_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] in1, in2, in3, in4, in5;
    logic [WIDTH-1:0] current_floor;
    logic [WIDTH-1:0] out1, out2, out3, out4, out5;
    logic [WIDTH-1:0] up_out1, up_out2, up_out3, up_out4, up_out5;
    logic [WIDTH-1:0] down_out1, down_out2, down_out3, down_out4, down_out5;
    logic             empty_upward_reg;
    logic             empty_downward_reg;
    logic [WIDTH-1:0] nextfloor;
    logic             up;
    logic             down;

    modport master (
        output in1, in2, in3, in4, in5, current_floor,
        input  out1, out2, out3, out4, out5,
        input  up_out1, up_out2, up_out3, up_out4, up_out5,
        input  down_out1, down_out2, down_out3, down_out4, down_out5,
        input  empty_upward_reg, empty_downward_reg, nextfloor, up, down
    );

    modport slave (
        input  in1, in2, in3, in4, in5, current_floor,
        output out1, out2, out3, out4, out5,
        output up_out1, up_out2, up_out3, up_out4, up_out5,
        output down_out1, down_out2, down_out3, down_out4, down_out5,
        output empty_upward_reg, empty_downward_reg, nextfloor, up, down
    );
endinterface

// File: rtl/floor_request_sorter.sv
// Sorts five floor requests, splits them around the current floor and picks the
// next target through an IDLE/UP/DOWN direction FSM. One-cycle registered latency.
module floor_request_sorter #(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    floor_request_sorter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

    localparam logic [WIDTH-1:0] SENTINEL = '1;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] req        [5];
    logic [WIDTH-1:0] sorted     [5];
    logic [WIDTH-1:0] up_list    [5];
    logic [WIDTH-1:0] down_list  [5];
    logic [WIDTH-1:0] swap_tmp;
    logic [2:0]       lt_cnt, le_cnt;
    logic             up_empty, down_empty;
    logic [WIDTH-1:0] dist_up, dist_down;
    logic [WIDTH-1:0] nextfloor_next;
    logic             up_next, down_next;

    logic [WIDTH-1:0] sorted_reg [5];
    logic [WIDTH-1:0] up_reg     [5];
    logic [WIDTH-1:0] down_reg   [5];
    logic             empty_up_reg, empty_down_reg;
    logic [WIDTH-1:0] nextfloor_reg;
    logic             up_cmd_reg, down_cmd_reg;

    assign req[0] = bus.in1;
    assign req[1] = bus.in2;
    assign req[2] = bus.in3;
    assign req[3] = bus.in4;
    assign req[4] = bus.in5;

    // Bubble network: passes of 4,3,2,1 compare-exchanges = 10 in total.
    always_comb begin
        swap_tmp = '0;
        sorted   = req;
        for (int p = 0; p < 4; p++) begin
            for (int j = 0; j < 4 - p; j++) begin
                if (sorted[j] > sorted[j+1]) begin
                    swap_tmp    = sorted[j];
                    sorted[j]   = sorted[j+1];
                    sorted[j+1] = swap_tmp;
                end
            end
        end
    end

    // With the list sorted, "below" is a prefix and "above" is a suffix.
    always_comb begin
        lt_cnt = 3'd0;
        le_cnt = 3'd0;
        for (int i = 0; i < 5; i++) begin
            if (sorted[i] < bus.current_floor)  lt_cnt = lt_cnt + 3'd1;
            if (sorted[i] <= bus.current_floor) le_cnt = le_cnt + 3'd1;
        end
        for (int k = 0; k < 5; k++) begin
            up_list[k]   = SENTINEL;
            down_list[k] = SENTINEL;
            if (int'(le_cnt) + k < 5)
                up_list[k] = sorted[int'(le_cnt) + k];
            if (k < int'(lt_cnt))
                down_list[k] = sorted[int'(lt_cnt) - 1 - k];
        end
        up_empty   = (le_cnt == 3'd5);
        down_empty = (lt_cnt == 3'd0);
        dist_up    = up_list[0] - bus.current_floor;
        dist_down  = bus.current_floor - down_list[0];
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (!up_empty && !down_empty)
                    state_next = (dist_up <= dist_down) ? UP : DOWN;
                else if (!up_empty)
                    state_next = UP;
                else if (!down_empty)
                    state_next = DOWN;
                else
                    state_next = IDLE;
            end
            UP:      state_next = !up_empty   ? UP   : (!down_empty ? DOWN : IDLE);
            DOWN:    state_next = !down_empty ? DOWN : (!up_empty   ? UP   : IDLE);
            default: state_next = IDLE;
        endcase

        nextfloor_next = bus.current_floor;
        up_next        = 1'b0;
        down_next      = 1'b0;
        case (state_next)
            UP: begin
                nextfloor_next = up_list[0];
                up_next        = 1'b1;
            end
            DOWN: begin
                nextfloor_next = down_list[0];
                down_next      = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            empty_up_reg   <= 1'b1;
            empty_down_reg <= 1'b1;
            nextfloor_reg  <= '0;
            up_cmd_reg     <= 1'b0;
            down_cmd_reg   <= 1'b0;
            for (int k = 0; k < 5; k++) begin
                sorted_reg[k] <= '0;
                up_reg[k]     <= SENTINEL;
                down_reg[k]   <= SENTINEL;
            end
        end else begin
            state_reg      <= state_next;
            empty_up_reg   <= up_empty;
            empty_down_reg <= down_empty;
            nextfloor_reg  <= nextfloor_next;
            up_cmd_reg     <= up_next;
            down_cmd_reg   <= down_next;
            for (int k = 0; k < 5; k++) begin
                sorted_reg[k] <= sorted[k];
                up_reg[k]     <= up_list[k];
                down_reg[k]   <= down_list[k];
            end
        end
    end

    assign bus.out1 = sorted_reg[0];
    assign bus.out2 = sorted_reg[1];
    assign bus.out3 = sorted_reg[2];
    assign bus.out4 = sorted_reg[3];
    assign bus.out5 = sorted_reg[4];
    assign bus.up_out1 = up_reg[0];
    assign bus.up_out2 = up_reg[1];
    assign bus.up_out3 = up_reg[2];
    assign bus.up_out4 = up_reg[3];
    assign bus.up_out5 = up_reg[4];
    assign bus.down_out1 = down_reg[0];
    assign bus.down_out2 = down_reg[1];
    assign bus.down_out3 = down_reg[2];
    assign bus.down_out4 = down_reg[3];
    assign bus.down_out5 = down_reg[4];
    assign bus.empty_upward_reg   = empty_up_reg;
    assign bus.empty_downward_reg = empty_down_reg;
    assign bus.nextfloor = nextfloor_reg;
    assign bus.up        = up_cmd_reg;
    assign bus.down      = down_cmd_reg;
endmodule

// File: tb/tb_floor_request_sorter.sv
// Directed and random checks of floor_request_sorter against a queue-based model.
module tb_floor_request_sorter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_compared = 0;
    int   n_mismatched = 0;

    floor_request_sorter_if #(.WIDTH(16)) bus ();

    floor_request_sorter #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] obs_out [5];
    logic [15:0] obs_up  [5];
    logic [15:0] obs_dn  [5];
    assign obs_out[0] = bus.out1;  assign obs_out[1] = bus.out2;  assign obs_out[2] = bus.out3;
    assign obs_out[3] = bus.out4;  assign obs_out[4] = bus.out5;
    assign obs_up[0] = bus.up_out1; assign obs_up[1] = bus.up_out2; assign obs_up[2] = bus.up_out3;
    assign obs_up[3] = bus.up_out4; assign obs_up[4] = bus.up_out5;
    assign obs_dn[0] = bus.down_out1; assign obs_dn[1] = bus.down_out2; assign obs_dn[2] = bus.down_out3;
    assign obs_dn[3] = bus.down_out4; assign obs_dn[4] = bus.down_out5;

    // Model state: direction 0 = idle, 1 = up, 2 = down.
    int          m_dir = 0;
    logic [15:0] e_out [5];
    logic [15:0] e_up  [5];
    logic [15:0] e_dn  [5];
    logic        e_eu, e_ed, e_upc, e_dnc;
    logic [15:0] e_nf;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input int r[5], input int cf);
        int srt[$];
        int ups[$];
        int dns[$];
        int nd;
        srt = {r[0], r[1], r[2], r[3], r[4]};
        srt.sort();
        foreach (srt[i]) if (srt[i] > cf) ups.push_back(srt[i]);
        for (int i = 4; i >= 0; i--) if (srt[i] < cf) dns.push_back(srt[i]);
        for (int k = 0; k < 5; k++) begin
            e_out[k] = 16'(srt[k]);
            e_up[k]  = (k < ups.size()) ? 16'(ups[k]) : 16'hFFFF;
            e_dn[k]  = (k < dns.size()) ? 16'(dns[k]) : 16'hFFFF;
        end
        e_eu = (ups.size() == 0);
        e_ed = (dns.size() == 0);
        nd = 0;
        if (m_dir == 0) begin
            if (ups.size() > 0 && dns.size() > 0) nd = ((ups[0] - cf) <= (cf - dns[0])) ? 1 : 2;
            else if (ups.size() > 0) nd = 1;
            else if (dns.size() > 0) nd = 2;
        end else if (m_dir == 1) begin
            nd = (ups.size() > 0) ? 1 : (dns.size() > 0 ? 2 : 0);
        end else begin
            nd = (dns.size() > 0) ? 2 : (ups.size() > 0 ? 1 : 0);
        end
        m_dir = nd;
        e_nf  = (nd == 1) ? 16'(ups[0]) : (nd == 2) ? 16'(dns[0]) : 16'(cf);
        e_upc = (nd == 1);
        e_dnc = (nd == 2);
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("%s.out%0d", tag, k + 1), obs_out[k], e_out[k]);
            check($sformatf("%s.up%0d", tag, k + 1), obs_up[k], e_up[k]);
            check($sformatf("%s.dn%0d", tag, k + 1), obs_dn[k], e_dn[k]);
        end
        check({tag, ".empty_up"}, 16'(bus.empty_upward_reg), 16'(e_eu));
        check({tag, ".empty_dn"}, 16'(bus.empty_downward_reg), 16'(e_ed));
        check({tag, ".nextfloor"}, bus.nextfloor, e_nf);
        check({tag, ".up"}, 16'(bus.up), 16'(e_upc));
        check({tag, ".down"}, 16'(bus.down), 16'(e_dnc));
    endtask

    task automatic check_reset(input string tag);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("%s.out%0d", tag, k + 1), obs_out[k], 16'h0000);
            check($sformatf("%s.up%0d", tag, k + 1), obs_up[k], 16'hFFFF);
            check($sformatf("%s.dn%0d", tag, k + 1), obs_dn[k], 16'hFFFF);
        end
        check({tag, ".empty_up"}, 16'(bus.empty_upward_reg), 16'h1);
        check({tag, ".empty_dn"}, 16'(bus.empty_downward_reg), 16'h1);
        check({tag, ".nextfloor"}, bus.nextfloor, 16'h0000);
        check({tag, ".up"}, 16'(bus.up), 16'h0);
        check({tag, ".down"}, 16'(bus.down), 16'h0);
    endtask

    // Drive one request set, clock it in, then compare against the model.
    task automatic step(input string tag, input int a, input int b, input int c,
                        input int d, input int e, input int cf);
        int r[5];
        r = '{a, b, c, d, e};
        bus.in1 = 16'(a); bus.in2 = 16'(b); bus.in3 = 16'(c);
        bus.in4 = 16'(d); bus.in5 = 16'(e); bus.current_floor = 16'(cf);
        @(posedge clk);
        #1;
        model_step(r, cf);
        check_all(tag);
        $display("txn %s: in=%0d,%0d,%0d,%0d,%0d cf=%0d -> nextfloor=%0d up=%0b down=%0b",
                 tag, a, b, c, d, e, cf, bus.nextfloor, bus.up, bus.down);
    endtask

    initial begin
        bus.in1 = 16'd3; bus.in2 = 16'd9; bus.in3 = 16'd1;
        bus.in4 = 16'd7; bus.in5 = 16'd2; bus.current_floor = 16'd4;
        #12;
        check_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        step("all_below", 2, 1, 0, 4, 3, 5);
        check("all_below.nf_lit", bus.nextfloor, 16'd4);
        step("at_floor_excl", 2, 1, 0, 4, 3, 4);
        check("at_floor_excl.nf_lit", bus.nextfloor, 16'd3);
        check("at_floor_excl.dn5_lit", bus.down_out5, 16'hFFFF);
        step("to_idle1", 6, 6, 6, 6, 6, 6);
        step("split", 7, 9, 2, 5, 5, 5);
        check("split.nf_lit", bus.nextfloor, 16'd7);
        step("hysteresis", 2, 1, 8, 8, 8, 3);
        check("hysteresis.nf_lit", bus.nextfloor, 16'd8);
        step("to_idle2", 6, 6, 6, 6, 6, 6);
        step("dup_tie", 12, 8, 12, 8, 10, 10);
        check("dup_tie.nf_lit", bus.nextfloor, 16'd12);
        check("dup_tie.out3_lit", bus.out3, 16'd10);
        step("none_away", 6, 6, 6, 6, 6, 6);
        check("none_away.nf_lit", bus.nextfloor, 16'd6);
        step("floor0", 0, 0, 65534, 0, 1, 0);

        for (int t = 0; t < 300; t++) begin
            step($sformatf("rand%0d", t),
                 int'($urandom_range(0, 20)), int'($urandom_range(0, 20)),
                 int'($urandom_range(0, 20)), int'($urandom_range(0, 20)),
                 int'($urandom_range(0, 20)), int'($urandom_range(0, 20)));
        end

        // Mid-cycle asynchronous reset: values must drop without a clock edge.
        #3;
        rst_n = 1'b0;
        #1;
        check_reset("async_reset");
        m_dir = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int t = 0; t < 50; t++) begin
            step($sformatf("post%0d", t),
                 int'($urandom_range(0, 20)), int'($urandom_range(0, 20)),
                 int'($urandom_range(0, 20)), int'($urandom_range(0, 20)),
                 int'($urandom_range(0, 20)), int'($urandom_range(0, 20)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
